// File: rtl/entity_table.sv
// Entity record store with a one-slot-per-cycle motion sweep, spawn allocation and delete.
// Optional feature macro: ENTITY_TABLE_LIFETIME_EN (aux field becomes a self-expiring lifetime counter).
module entity_table #(
    parameter int NUM_SLOTS   = 8,
    parameter int ENTITY_SIZE = 34,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               move_tick,
    input  logic                               spawn_valid,
    output logic                               spawn_ready,
    input  logic [ENTITY_SIZE-1:0]             spawn_data,
    output logic [$clog2(NUM_SLOTS)-1:0]       spawn_idx,
    input  logic                               delete_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0]       delete_idx,
    output logic [NUM_SLOTS*ENTITY_SIZE-1:0]   entities,
    output logic [$clog2(NUM_SLOTS):0]         active_count,
    output logic                               full,
    output logic                               busy,
    output logic                               sweep_done,
    output logic                               overrun
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       sweep_idx_q, sweep_idx_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic                   sweep_done_q, sweep_done_d;
    logic [ENTITY_SIZE-1:0] slot_q [NUM_SLOTS];
    logic [ENTITY_SIZE-1:0] slot_d [NUM_SLOTS];
    logic [ENTITY_SIZE-1:0] swept;
    logic [ENTITY_SIZE-1:0] moved;
    logic                   spawn_fire;
    logic                   last_slot;

    // Positions are unsigned 10-bit, velocities signed 3-bit; one wrap correction only.
    function automatic logic [9:0] wrap_axis(input logic [9:0] pos,
                                             input logic [2:0] vel,
                                             input logic signed [10:0] modulus);
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos}) + $signed({{8{vel[2]}}, vel});
        if (sum < 0)
            return 10'(sum + modulus);
        else if (sum >= modulus)
            return 10'(sum - modulus);
        else
            return 10'(sum);
    endfunction

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            active_count = active_count + CNT_W'(slot_q[i][33]);
    end

    always_comb begin
        spawn_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!slot_q[i][33])
                spawn_idx = IDX_W'(i);
    end

    assign full        = (active_count == CNT_W'(NUM_SLOTS));
    assign spawn_ready = (state_q == IDLE) && !full;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign busy        = (state_q == SWEEP);
    assign sweep_done  = sweep_done_q;
    assign overrun     = overrun_q;
    assign last_slot   = (sweep_idx_q == IDX_W'(NUM_SLOTS - 1));

    always_comb begin
        swept = slot_q[sweep_idx_q];
        moved = swept;
        moved[15:6]  = wrap_axis(swept[15:6],  swept[2:0], 11'(SCREEN_W));
        moved[25:16] = wrap_axis(swept[25:16], swept[5:3], 11'(SCREEN_H));
`ifdef ENTITY_TABLE_LIFETIME_EN
        if (swept[29:26] == 4'd1)
            moved = '0;
        else if (swept[29:26] != 4'd0)
            moved[29:26] = swept[29:26] - 4'd1;
`endif
    end

    // Priority per slot: spawn, then sweep update, then delete (delete always wins).
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (spawn_fire && spawn_idx == IDX_W'(i))
                slot_d[i] = spawn_data | {1'b1, {(ENTITY_SIZE-1){1'b0}}};
            if (state_q == SWEEP && sweep_idx_q == IDX_W'(i) && slot_q[i][33])
                slot_d[i] = moved;
            if (delete_valid && delete_idx == IDX_W'(i) && slot_q[i][33])
                slot_d[i] = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        sweep_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (move_tick || pending_q) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                    pending_d   = move_tick && pending_q;
                end
            end
            SWEEP: begin
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (move_tick) begin
                    if (pending_q)
                        overrun_d = 1'b1;
                    else
                        pending_d = 1'b1;
                end
                // A pending tick restarts the sweep without an idle cycle.
                if (last_slot) begin
                    sweep_done_d = 1'b1;
                    sweep_idx_d  = '0;
                    if (pending_q)
                        pending_d = 1'b0;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= IDLE;
            sweep_idx_q  <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            sweep_done_q <= sweep_done_d;
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_q[i] <= slot_d[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
        assign entities[g*ENTITY_SIZE +: ENTITY_SIZE] = slot_q[g];
    end
endmodule

// File: tb/tb_entity_table.sv
// Self-checking bench for entity_table: sweep results are scoreboarded from a behavioural model.
module tb_entity_table;
    localparam int N  = 8;
    localparam int W  = 34;
    localparam int SW = 320;
    localparam int SH = 240;
`ifdef ENTITY_TABLE_LIFETIME_EN
    localparam bit LIFE = 1'b1;
`else
    localparam bit LIFE = 1'b0;
`endif

    logic           clk;
    logic           reset_n;
    logic           move_tick;
    logic           spawn_valid;
    logic           spawn_ready;
    logic [W-1:0]   spawn_data;
    logic [2:0]     spawn_idx;
    logic           delete_valid;
    logic [2:0]     delete_idx;
    logic [N*W-1:0] entities;
    logic [3:0]     active_count;
    logic           full;
    logic           busy;
    logic           sweep_done;
    logic           overrun;

    int checks = 0;
    int failures = 0;
    int sweepNum = 0;
    logic [W-1:0]   model [N];
    logic [N*W-1:0] expQ [$];

    entity_table #(.NUM_SLOTS(N), .ENTITY_SIZE(W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset_n(reset_n), .move_tick(move_tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_data(spawn_data),
        .spawn_idx(spawn_idx), .delete_valid(delete_valid), .delete_idx(delete_idx),
        .entities(entities), .active_count(active_count), .full(full), .busy(busy),
        .sweep_done(sweep_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] mkRec(input logic [2:0] typ, input logic [3:0] aux,
                                           input logic [9:0] y, input logic [9:0] x, input logic [5:0] dir);
        return {1'b0, typ, aux, y, x, dir};
    endfunction

    function automatic logic [W-1:0] getSlot(input int i);
        return entities[i*W +: W];
    endfunction

    function automatic int modelFree();
        for (int i = 0; i < N; i++)
            if (!model[i][33]) return i;
        return -1;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < N; i++)
            if (model[i][33]) c++;
        return c;
    endfunction

    function automatic logic [N*W-1:0] packModel();
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++)
            p[i*W +: W] = model[i];
        return p;
    endfunction

    function automatic logic [W-1:0] moveRec(input logic [W-1:0] r);
        logic [W-1:0] o;
        int x, y, vx, vy;
        o = r;
        if (r[33]) begin
            vx = int'(r[2:0]);
            if (vx > 3) vx -= 8;
            vy = int'(r[5:3]);
            if (vy > 3) vy -= 8;
            x = int'(r[15:6]) + vx;
            if (x < 0) x += SW; else if (x >= SW) x -= SW;
            y = int'(r[25:16]) + vy;
            if (y < 0) y += SH; else if (y >= SH) y -= SH;
            o[15:6]  = 10'(x);
            o[25:16] = 10'(y);
            if (LIFE) begin
                if (r[29:26] == 4'd1) o = '0;
                else if (r[29:26] != 4'd0) o[29:26] = r[29:26] - 4'd1;
            end
        end
        return o;
    endfunction

    task automatic pushSweep(input int delSlot);
        for (int i = 0; i < N; i++)
            model[i] = moveRec(model[i]);
        if (delSlot >= 0) model[delSlot] = '0;
        expQ.push_back(packModel());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic tick, input logic sv, input logic [W-1:0] sd,
                                 input logic dv, input logic [2:0] di);
        move_tick = tick; spawn_valid = sv; spawn_data = sd; delete_valid = dv; delete_idx = di;
        @(negedge clk);
        move_tick = 1'b0; spawn_valid = 1'b0; spawn_data = '0; delete_valid = 1'b0; delete_idx = '0;
    endtask

    task automatic waitSweepDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (sweep_done !== 1'b1 && cycles < 40);
        checkOutput("sweep_done_seen", 64'(sweep_done), 1);
    endtask

    task automatic doSpawn(input logic [W-1:0] rec, input logic tick, output int idx);
        logic [W-1:0] pre;
        idx = modelFree();
        checkOutput("spawn_ready", 64'(spawn_ready), 1);
        checkOutput("spawn_idx", 64'(spawn_idx), 64'(idx));
        model[idx] = rec | {1'b1, 33'b0};
        pre = model[idx];
        if (tick) pushSweep(-1);
        applyStimulus(tick, 1'b1, rec, 1'b0, 3'd0);
        checkOutput($sformatf("spawn_slot%0d", idx), 64'(getSlot(idx)), 64'(pre));
    endtask

    task automatic tickAndWait(output int total);
        int c;
        pushSweep(-1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        waitSweepDone(c);
        total = c + 1;
    endtask

    // Every sweep_done pops one expected table snapshot.
    always @(negedge clk) begin
        logic [N*W-1:0] e;
        if (sweep_done === 1'b1) begin
            checkOutput("sweep_expected_queued", 64'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                sweepNum++;
                for (int i = 0; i < N; i++)
                    checkOutput($sformatf("sweep%0d_slot%0d", sweepNum, i),
                                64'(entities[i*W +: W]), 64'(e[i*W +: W]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx, c, bIdx, cIdx, dIdx;
        logic [W-1:0] r;
        reset_n = 1'b1;
        move_tick = 1'b0; spawn_valid = 1'b0; spawn_data = '0; delete_valid = 1'b0; delete_idx = '0;
        for (int i = 0; i < N; i++) model[i] = '0;
        idle(3);
        checkOutput("rst_entities", 64'(entities != '0), 0);
        checkOutput("rst_active_count", 64'(active_count), 0);
        checkOutput("rst_full", 64'(full), 0);
        checkOutput("rst_busy", 64'(busy), 0);
        checkOutput("rst_sweep_done", 64'(sweep_done), 0);
        checkOutput("rst_overrun", 64'(overrun), 0);
        checkOutput("rst_spawn_ready", 64'(spawn_ready), 1);
        reset_n = 1'b0;
        idle(1);

        $display("[TB] basic spawn and move");
        doSpawn(mkRec(3'd1, 4'd2, 10'd20, 10'd10, 6'b111_001), 1'b0, idx);
        checkOutput("first_spawn_active_count", 64'(active_count), 1);
        tickAndWait(c);
        checkOutput("sweep_done_latency", 64'(c), 9);
        r = getSlot(0);
        checkOutput("A_x", 64'(r[15:6]), 11);
        checkOutput("A_y", 64'(r[25:16]), 19);
        checkOutput("A_aux", 64'(r[29:26]), LIFE ? 1 : 2);

        $display("[TB] wrap with spawn and tick in one cycle");
        doSpawn(mkRec(3'd2, 4'd0, 10'd0, 10'd319, 6'b100_011), 1'b1, bIdx);
        waitSweepDone(c);
        checkOutput("same_cycle_latency", 64'(c + 1), 9);
        r = getSlot(bIdx);
        checkOutput("B_x_wrap", 64'(r[15:6]), 2);
        checkOutput("B_y_wrap", 64'(r[25:16]), 236);

        $display("[TB] out-of-range spawn and low-edge wrap");
        doSpawn(mkRec(3'd3, 4'd0, 10'd245, 10'd330, 6'b000_000), 1'b0, cIdx);
        doSpawn(mkRec(3'd3, 4'd0, 10'd239, 10'd0, 6'b001_111), 1'b0, dIdx);
        tickAndWait(c);
        r = getSlot(cIdx);
        checkOutput("C_x_reduced", 64'(r[15:6]), 10);
        checkOutput("C_y_reduced", 64'(r[25:16]), 5);
        r = getSlot(dIdx);
        checkOutput("D_x_wrap", 64'(r[15:6]), 319);
        checkOutput("D_y_wrap", 64'(r[25:16]), 0);

        $display("[TB] fill table");
        for (int k = 0; k < N && modelFree() >= 0; k++)
            doSpawn(mkRec(3'd4, 4'd0, 10'(k * 20), 10'(k * 30), 6'(k * 9)), 1'b0, idx);
        checkOutput("full_flag", 64'(full), 1);
        checkOutput("full_spawn_ready", 64'(spawn_ready), 0);
        checkOutput("full_active_count", 64'(active_count), 8);
        applyStimulus(1'b0, 1'b1, mkRec(3'd7, 4'd0, 10'd1, 10'd1, 6'd0), 1'b0, 3'd0);
        checkOutput("spawn_when_full_ignored", 64'(active_count), 8);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 3'd3);
        model[3] = '0;
        checkOutput("del3_active_count", 64'(active_count), 7);
        checkOutput("del3_full", 64'(full), 0);
        checkOutput("del3_slot", 64'(getSlot(3)), 0);
        checkOutput("del3_spawn_idx", 64'(spawn_idx), 3);
        doSpawn(mkRec(3'd5, 4'd0, 10'd100, 10'd100, 6'b010_110), 1'b0, idx);
        checkOutput("refill_slot", 64'(idx), 3);

        $display("[TB] back-to-back sweeps");
        pushSweep(-1);
        pushSweep(-1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        idle(4);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        waitSweepDone(c);
        checkOutput("b2b_first_done_at", 64'(c), 3);
        checkOutput("b2b_busy_reentered", 64'(busy), 1);
        waitSweepDone(c);
        checkOutput("b2b_second_done_at", 64'(c), 8);
        checkOutput("b2b_overrun", 64'(overrun), 0);
        idle(2);
        checkOutput("b2b_idle_after", 64'(busy), 0);

        $display("[TB] delete during sweep");
        pushSweep(5);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        idle(5);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 3'd5);
        waitSweepDone(c);
        checkOutput("del_sweep_slot5", 64'(getSlot(5)), 0);
        checkOutput("del_sweep_active_count", 64'(active_count), 64'(modelCount()));

        $display("[TB] overrun");
        pushSweep(-1);
        pushSweep(-1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        idle(2);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        checkOutput("overrun_set", 64'(overrun), 1);
        waitSweepDone(c);
        waitSweepDone(c);
        idle(12);
        checkOutput("overrun_sticky", 64'(overrun), 1);
        checkOutput("overrun_no_third_sweep", 64'(busy), 0);
        checkOutput("overrun_queue_drained", 64'(expQ.size()), 0);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        checkOutput("midrst_entities", 64'(entities != '0), 0);
        checkOutput("midrst_busy", 64'(busy), 0);
        checkOutput("midrst_overrun", 64'(overrun), 0);
        checkOutput("midrst_active_count", 64'(active_count), 0);
        for (int i = 0; i < N; i++) model[i] = '0;
        reset_n = 1'b0;
        idle(2);
        checkOutput("midrst_no_resume", 64'(busy), 0);

        $display("[TB] lifetime");
        doSpawn(mkRec(3'd2, 4'd2, 10'd60, 10'd50, 6'b001_001), 1'b0, idx);
        tickAndWait(c);
        r = getSlot(idx);
        checkOutput("life_aux_after_tick1", 64'(r[29:26]), LIFE ? 1 : 2);
        checkOutput("life_x_after_tick1", 64'(r[15:6]), 51);
        tickAndWait(c);
        r = getSlot(idx);
        checkOutput("life_active_after_tick2", 64'(r[33]), LIFE ? 0 : 1);
        checkOutput("life_active_count", 64'(active_count), LIFE ? 0 : 1);

        idle(2);
        checkOutput("final_queue_empty", 64'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/entity_table.md
# entity_table

Parametrised store and motion engine for the game's entity records (ship, asteroids, shots). Holds `NUM_SLOTS` entity records in the shared 34-bit entity format. Each `move_tick` it sweeps every active slot once, applying its velocity with screen wrap-around. Spawn and delete ports let the shot and asteroid controllers allocate and free slots. The flattened table feeds the draw controller directly.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of entity slots; must be at least 2.
- `ENTITY_SIZE`, 34: record width; the fields below are fixed for 34.
- `SCREEN_W`, 320: x wrap modulus.
- `SCREEN_H`, 240: y wrap modulus.

Ports:
- `clk`, in, 1: system clock; one clock domain.
- `reset_n`, in, 1: reset is asynchronous and active-high. The codebase names it `reset_n`; it is active-high despite the suffix.
- `move_tick`, in, 1: one-cycle pulse that requests a motion sweep.
- `spawn_valid`, in, 1: spawn request.
- `spawn_ready`, out, 1: spawn can be accepted this cycle.
- `spawn_data`, in, 34: record to store. Bit [33] is ignored and forced to 1.
- `spawn_idx`, out, clog2(N): slot that the current spawn will occupy.
- `delete_valid`, in, 1: delete request.
- `delete_idx`, in, clog2(N): slot to clear.
- `entities`, out, N*34: slot i occupies bits [i*34+33 : i*34].
- `active_count`, out, clog2(N)+1: number of slots with bit [33] set.
- `full`, out, 1: all slots are active.
- `busy`, out, 1: a sweep is in progress.
- `sweep_done`, out, 1: one-cycle pulse after a sweep finishes.
- `overrun`, out, 1: sticky flag. Set when `move_tick` arrives while a tick is already pending. Cleared only by reset.

Record fields:
- [33] active.
- [32:30] type.
- [29:26] aux.
- [25:16] y.
- [15:6] x.
- [5:0] direction: vx = signed dir[2:0], vy = signed dir[5:3], range −4..+3 each.

## Operation
- FSM states: IDLE, SWEEP.
- IDLE:
  - `move_tick` or a pending tick moves the FSM to SWEEP on the next edge, with the sweep index at 0.
- SWEEP:
  - One slot is processed per cycle, index 0 to N−1.
  - An inactive slot is left unchanged.
  - After slot N−1 the FSM returns to IDLE and pulses `sweep_done`.
- Motion arithmetic, per axis:
  - Compute in 11-bit signed: s = pos + v.
  - If s < 0, the new position is s + modulus.
  - If s ≥ modulus, the new position is s − modulus.
  - Otherwise the new position is s.
  - A spawned position that is already ≥ modulus is reduced once by the same rule on its first sweep.
- Spawn:
  - `spawn_ready` = (state == IDLE) and not `full`.
  - `spawn_idx` is the lowest inactive slot; this is combinational.
  - When `spawn_valid` and `spawn_ready` are both high, the record is written at the clock edge with [33] = 1.
- Delete:
  - Accepted in any state, every cycle; there is no handshake.
  - Clears the whole slot to 0 at the edge.
  - If the slot is being swept in that same cycle, the delete wins.
  - Deleting an inactive slot has no effect.
- Tick pending:
  - A `move_tick` during SWEEP, or in the same cycle as the SWEEP entry, sets `pending`.
  - A second tick while `pending` is already set sets `overrun` and is dropped.
  - On leaving SWEEP with `pending` set, the FSM re-enters SWEEP immediately and clears `pending`.
- Derived outputs:
  - `active_count` and `full` are combinational over the bit [33] values.

## Timing
- Reset values: all slots = 0, `active_count` = 0, `full` = 0, `busy` = 0, `sweep_done` = 0, `overrun` = 0, `pending` = 0, FSM = IDLE.
- Reset mid-sweep aborts the sweep immediately; no partial results are kept.
- Latency: a tick sampled at edge k causes slot i to be updated at edge k+1+i.
  - `sweep_done` is high in the cycle following edge k+N.
  - `busy` is high from edge k to edge k+N.
- A spawn and a tick in the same IDLE cycle:
  - The spawn is written at edge k.
  - The new entity is moved by the sweep that starts at edge k+1.
- A spawn and a delete in the same cycle always target different slots, since spawn only targets free slots. Both take effect.
- `entities` reflects register state; it has no combinational path from the inputs.

## Configuration
- Macro: `ENTITY_TABLE_LIFETIME_EN`.
- When defined:
  - aux [29:26] is a lifetime counter.
  - At each sweep of an active slot, a nonzero counter is decremented.
  - A slot swept with aux = 1 is cleared to 0 in that same sweep cycle instead of being moved.
  - aux = 0 means the entity never expires.
- When undefined:
  - aux is carried through unchanged.
  - No entity self-deletes.

## Test plan
- Reset then spawn: assert reset; expect all outputs 0. Spawn {x=10, y=20, dir=6'b111_001} into slot 0, then tick. Expect x=11, y=19, `sweep_done` 9 cycles after the tick (N=8).
- Wrap: spawn x=319, vx=+3, y=0, vy=−4, then tick. Expect x=2 and y=236.
- Full: perform 8 spawns. Expect `full` = 1, `spawn_ready` = 0, `active_count` = 8. Delete slot 3; the next spawn lands in slot 3.
- Collision of events: tick, then a second tick at sweep cycle 4. Expect two back-to-back sweeps and `overrun` = 0. A third tick during the second sweep while `pending` is still set gives `overrun` = 1.
- Delete during sweep: delete slot 5 in the same cycle it is swept. Expect slot 5 = 0 and `active_count` decremented.
- Lifetime, with `ENTITY_TABLE_LIFETIME_EN` defined: spawn with aux = 2. After tick 1 expect aux = 1 and the entity moved. After tick 2 expect the slot cleared. With the macro undefined, aux stays 2.
